alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU in the single-cycle processor datapath. It keeps the existing 5-bit opcode map. It adds a configurable data width, a registered flag register, iterative one-bit-per-cycle shifts and rotates, and an iterative shift-add multiplier that returns a double-width product. It sits between register read and writeback in the multi-cycle core and stalls the issue stage through valid/ready.

## Interface
- `WIDTH`, default 8: data width; ≥ 4.
- `CNT_W`, default $clog2(WIDTH+1): width of the iteration counter.
- `clk` input, 1 bit: the single clock; all state is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: operation request.
- `in_ready` output, 1 bit: the block accepts a request this cycle.
- `alu_op` input, 5 bits: opcode, same encoding as the current ALU.
- `src_a` input, `WIDTH` bits: operand A.
- `src_b` input, `WIDTH` bits: operand B, or the shift/rotate amount.
- `out_valid` output, 1 bit: result available.
- `out_ready` input, 1 bit: consumer takes the result.
- `result` output, `WIDTH` bits: primary result.
- `result2` output, `WIDTH` bits: secondary result (see Operation).
- `flags` output, 4 bits: {N, Z, C, V}, registered.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE→DONE happens on acceptance of a single-cycle op.
- IDLE→BUSY happens on acceptance of a shift, rotate or MUL with nonzero iteration count.
- BUSY→DONE happens when the counter reaches 0.
- DONE→IDLE happens on out_ready. If a new in_valid arrives in the same cycle, DONE→DONE or DONE→BUSY instead.
- `in_ready` is high in IDLE, and in DONE while `out_ready` is high.
- Operands and opcode are latched at acceptance. Input changes after acceptance have no effect.
- Single-cycle ops:
  - ADD 00001, SUB 00011, CMP 10100, INC 01111 (A+1), DEC 10000 (A−1).
  - AND 00010, OR 00100, XOR 00101, NOT 01000.
  - MOV 00110, LI 10101, LM 10110, branch 11111, and any undefined opcode: result = B.
  - NOP 00000: result = 0.
  - XCHG 00111: result = B, result2 = A.
- Arithmetic flags:
  - C is the carry-out for ADD and INC, and the borrow (A < B unsigned) for SUB, CMP and DEC.
  - V is signed overflow.
  - N = result[WIDTH−1]; Z = result == 0.
- Logic ops and NOT: C = 0, V = 0; N and Z from the result.
- Shifts: SAR 01001, SLR 01010, SAL 01011, SLL 01100.
  - Count = min(B, WIDTH).
  - One bit is shifted per BUSY cycle.
  - C = last bit shifted out, or 0 when count = 0.
  - V = result MSB ≠ A MSB.
- Rotates: ROL 01101, ROR 01110.
  - Count = B mod WIDTH.
  - C = the last bit rotated across the boundary, or 0 when count = 0.
  - V as for shifts.
- MUL 10001: unsigned shift-add, always WIDTH iterations.
  - result = low half of the product, result2 = high half.
  - C = V = (high half ≠ 0).
  - N and Z are computed from the full 2·WIDTH product.
- `result2` = 0 for every op other than XCHG and MUL.
- Flags update once, on the cycle DONE is entered.
- MOV, LI, LM, branch, NOP and undefined opcodes leave `flags` unchanged.
- CMP writes flags and result; the core ignores the result.

## Timing
- Reset values: state IDLE, `out_valid` 0, `in_ready` 1, `result` 0, `result2` 0, `flags` 0000, counter 0.
- Reset asserted mid-BUSY or in DONE aborts the operation and drops any pending result.
- Acceptance is cycle 0. `out_valid` rises at:
  - cycle 1 for single-cycle ops and for zero-count shifts/rotates;
  - cycle 1+count for shifts and rotates;
  - cycle 1+WIDTH for MUL.
- `result`, `result2` and `flags` are held stable while `out_valid` is high and `out_ready` is low.
- Back-to-back operation: with `out_ready` tied high, single-cycle ops sustain one op per cycle.
- `in_ready` is low throughout BUSY.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams, including the new MUL 10001;
  - the state typedef (IDLE/BUSY/DONE);
  - flag bit indices N=3, Z=2, C=1, V=0.
- Sub-module `alu_iter`: the iterative datapath for shift, rotate and MUL. It has the shift register, the accumulator, the counter and a done strobe, parametrised by `WIDTH`.
- The top level holds the combinational single-cycle ops, the FSM, the handshake and the flag register.

## Test plan
All scenarios use `WIDTH`=8.
1. ADD 0x7F+0x01 → result 0x80, flags 1001, `out_valid` at cycle 1.
2. SUB 0x00−0x01 → 0xFF, flags 1010. Then MOV 0x55 → result 0x55 with flags still 1010.
3. SAR 0x90 by 2 → 0xE4, C=0, `out_valid` at cycle 3.
   - ROL 0x81 by 1 → 0x03, C=1.
   - SLR 0x80 by 9 → 0x00, Z=1, `out_valid` at cycle 9.
4. MUL 0x12×0x34 → result 0xA8, result2 0x03, C=V=1, `out_valid` at cycle 9, `in_ready` low on cycles 1–8.
5. XCHG A=0x3C, B=0xC3 → result 0xC3, result2 0x3C.
   - Hold `out_ready` low 5 cycles → outputs stable, `in_ready` low.
   - Release `out_ready` with a new ADD valid → ADD accepted in that same cycle.
6. Deassert `rst_n` at cycle 4 of a MUL → `out_valid` 0, `flags` 0000, `in_ready` 1 asynchronously. Next ADD 0x01+0x01 → 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, controller states and flag bit positions.
package alu_pkg;

   localparam logic [4:0] op_nop  = 5'b00000;
   localparam logic [4:0] op_add  = 5'b00001;
   localparam logic [4:0] op_and  = 5'b00010;
   localparam logic [4:0] op_sub  = 5'b00011;
   localparam logic [4:0] op_or   = 5'b00100;
   localparam logic [4:0] op_xor  = 5'b00101;
   localparam logic [4:0] op_mov  = 5'b00110;
   localparam logic [4:0] op_xchg = 5'b00111;
   localparam logic [4:0] op_not  = 5'b01000;
   localparam logic [4:0] op_sar  = 5'b01001;
   localparam logic [4:0] op_slr  = 5'b01010;
   localparam logic [4:0] op_sal  = 5'b01011;
   localparam logic [4:0] op_sll  = 5'b01100;
   localparam logic [4:0] op_rol  = 5'b01101;
   localparam logic [4:0] op_ror  = 5'b01110;
   localparam logic [4:0] op_inc  = 5'b01111;
   localparam logic [4:0] op_dec  = 5'b10000;
   localparam logic [4:0] op_mul  = 5'b10001;
   localparam logic [4:0] op_cmp  = 5'b10100;
   localparam logic [4:0] op_li   = 5'b10101;
   localparam logic [4:0] op_lm   = 5'b10110;
   localparam logic [4:0] op_br   = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam int unsigned flag_n = 3;
   localparam int unsigned flag_z = 2;
   localparam int unsigned flag_c = 1;
   localparam int unsigned flag_v = 0;

   function automatic logic is_shift(logic [4:0] op);
      return op inside {op_sar, op_slr, op_sal, op_sll};
   endfunction

   function automatic logic is_rot(logic [4:0] op);
      return op inside {op_rol, op_ror};
   endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifts/rotates and a shift-add multiplier.
// lo/hi/cout present the values after the current step, so the caller can latch them on done.
module alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] count,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             cout
);

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       op_q;
   logic [WIDTH:0]   sum;

   always_comb begin
      sh_d  = sh_q;
      acc_d = acc_q;
      cout  = 1'b0;
      sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
      case (op_q)
         op_sar: begin
            sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            cout = sh_q[0];
         end
         op_slr: begin
            sh_d = {1'b0, sh_q[WIDTH-1:1]};
            cout = sh_q[0];
         end
         op_sal, op_sll: begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
            cout = sh_q[WIDTH-1];
         end
         op_rol: begin
            sh_d = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
            cout = sh_q[WIDTH-1];
         end
         op_ror: begin
            sh_d = {sh_q[0], sh_q[WIDTH-1:1]};
            cout = sh_q[0];
         end
         default: begin
            // {acc, sh} is the product register; multiplier bits retire from sh[0]
            acc_d = sum[WIDTH:1];
            sh_d  = {sum[0], sh_q[WIDTH-1:1]};
         end
      endcase
   end

   assign done = (cnt_q == CNT_W'(1));
   assign lo   = sh_d;
   assign hi   = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         op_q    <= op_nop;
      end else if (start) begin
         sh_q    <= a;
         acc_q   <= '0;
         mcand_q <= b;
         cnt_q   <= count;
         op_q    <= op;
      end else if (cnt_q != '0) begin
         sh_q  <= sh_d;
         acc_q <= acc_d;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops resolved at acceptance, shifts/rotates/MUL via alu_iter.
// Holds the IDLE/BUSY/DONE controller, the result registers and the flag register.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result2,
   output logic [3:0]       flags
);

   localparam int unsigned    msb     = WIDTH - 1;
   localparam logic [WIDTH:0] width_x = (WIDTH + 1)'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, result2_q, result2_d;
   logic [3:0]       flags_q, flags_d;
   logic [4:0]       op_q, op_d;
   logic             a_msb_q, a_msb_d;
   logic             accept, start;

   logic [WIDTH-1:0] arith_b, sc_res, sc_res2;
   logic [WIDTH:0]   sum_x, dif_x, b_x, rot_x;
   logic             sc_c, sc_v, sc_upd;
   logic [3:0]       sc_flags;

   logic             it_op, it_done, it_cout, hi_nz;
   logic [CNT_W-1:0] it_cnt;
   logic [WIDTH-1:0] it_lo, it_hi;
   logic [3:0]       it_flags;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign result    = result_q;
   assign result2   = result2_q;
   assign flags     = flags_q;

   // Single-cycle ops, evaluated directly from the request
   always_comb begin
      arith_b = (alu_op == op_inc || alu_op == op_dec) ? WIDTH'(1) : src_b;
      sum_x   = {1'b0, src_a} + {1'b0, arith_b};
      dif_x   = {1'b0, src_a} - {1'b0, arith_b};
      sc_res  = src_b;
      sc_res2 = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      sc_upd  = 1'b0;
      case (alu_op)
         op_add, op_inc: begin
            sc_res = sum_x[WIDTH-1:0];
            sc_c   = sum_x[WIDTH];
            sc_v   = (src_a[msb] == arith_b[msb]) && (sum_x[msb] != src_a[msb]);
            sc_upd = 1'b1;
         end
         op_sub, op_cmp, op_dec: begin
            sc_res = dif_x[WIDTH-1:0];
            sc_c   = dif_x[WIDTH];
            sc_v   = (src_a[msb] != arith_b[msb]) && (dif_x[msb] != src_a[msb]);
            sc_upd = 1'b1;
         end
         op_and: begin sc_res = src_a & src_b; sc_upd = 1'b1; end
         op_or:  begin sc_res = src_a | src_b; sc_upd = 1'b1; end
         op_xor: begin sc_res = src_a ^ src_b; sc_upd = 1'b1; end
         op_not: begin sc_res = ~src_a;        sc_upd = 1'b1; end
         op_nop: sc_res = '0;
         // XCHG is a register move: flags are kept
         op_xchg: sc_res2 = src_a;
         // Only reached with a zero count: operand passes through, C and V clear
         op_sar, op_slr, op_sal, op_sll, op_rol, op_ror: begin
            sc_res = src_a;
            sc_upd = 1'b1;
         end
         default: sc_res = src_b;
      endcase
      sc_flags = {sc_res[msb], sc_res == '0, sc_c, sc_v};
   end

   always_comb begin
      b_x   = {1'b0, src_b};
      rot_x = b_x % width_x;
      it_op = is_shift(alu_op) || is_rot(alu_op) || (alu_op == op_mul);
      if (is_rot(alu_op)) begin
         it_cnt = CNT_W'(rot_x);
      end else if (is_shift(alu_op)) begin
         it_cnt = (b_x >= width_x) ? CNT_W'(WIDTH) : CNT_W'(b_x);
      end else begin
         it_cnt = CNT_W'(WIDTH);
      end
   end

   alu_iter #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_iter (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .op   (alu_op),
      .a    (src_a),
      .b    (src_b),
      .count(it_cnt),
      .done (it_done),
      .lo   (it_lo),
      .hi   (it_hi),
      .cout (it_cout)
   );

   always_comb begin
      hi_nz = (it_hi != '0);
      if (op_q == op_mul) begin
         it_flags = {it_hi[msb], {it_hi, it_lo} == '0, hi_nz, hi_nz};
      end else begin
         it_flags = {it_lo[msb], it_lo == '0, it_cout, it_lo[msb] != a_msb_q};
      end
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      result2_d = result2_q;
      flags_d   = flags_q;
      op_d      = op_q;
      a_msb_d   = a_msb_q;
      start     = 1'b0;
      case (state_q)
         BUSY: begin
            if (it_done) begin
               state_d   = DONE;
               result_d  = it_lo;
               result2_d = (op_q == op_mul) ? it_hi : '0;
               flags_d   = it_flags;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: ;
      endcase
      // Acceptance overrides the DONE drain so back-to-back ops never bubble
      if (accept) begin
         op_d    = alu_op;
         a_msb_d = src_a[msb];
         if (it_op && (it_cnt != '0)) begin
            state_d = BUSY;
            start   = 1'b1;
         end else begin
            state_d   = DONE;
            result_d  = sc_res;
            result2_d = sc_res2;
            if (sc_upd) flags_d = sc_flags;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         result2_q <= '0;
         flags_q   <= '0;
         op_q      <= op_nop;
         a_msb_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         result2_q <= result2_d;
         flags_q   <= flags_d;
         op_q      <= op_d;
         a_msb_q   <= a_msb_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against a
// behavioural model written directly from the opcode rules.
module tb_alu_seq;

   localparam int W    = 8;
   localparam int MAXS = (1 << (W - 1)) - 1;
   localparam int MINS = -(1 << (W - 1));

   localparam logic [4:0] T_NOP = 5'b00000, T_ADD = 5'b00001, T_AND = 5'b00010;
   localparam logic [4:0] T_SUB = 5'b00011, T_OR = 5'b00100, T_XOR = 5'b00101;
   localparam logic [4:0] T_MOV = 5'b00110, T_XCHG = 5'b00111, T_NOT = 5'b01000;
   localparam logic [4:0] T_SAR = 5'b01001, T_SLR = 5'b01010, T_SAL = 5'b01011;
   localparam logic [4:0] T_SLL = 5'b01100, T_ROL = 5'b01101, T_ROR = 5'b01110;
   localparam logic [4:0] T_INC = 5'b01111, T_DEC = 5'b10000, T_MUL = 5'b10001;
   localparam logic [4:0] T_CMP = 5'b10100;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]   alu_op;
   logic [W-1:0] src_a, src_b, result, result2;
   logic [3:0]   flags;

   int           n_checks, n_fail;
   logic [3:0]   mflags;
   logic [W-1:0] obs_res, obs_res2;
   logic [3:0]   obs_flags;
   int           obs_lat;

   always #5 clk = ~clk;

   alu_seq #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alu_op   (alu_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .result2  (result2),
      .flags    (flags)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected result, result2, latency; updates mflags as the ALU would.
   task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [W-1:0] r2, output int lat);
      int su, ss, sa, sb, k, p;
      logic [W-1:0]   bb;
      logic [2*W-1:0] aa;
      logic           c, v, upd;
      sa  = $signed(a);
      r   = b;
      r2  = '0;
      c   = 1'b0;
      v   = 1'b0;
      upd = 1'b0;
      lat = 1;
      p   = 0;
      case (op)
         T_ADD, T_INC: begin
            bb  = (op == T_INC) ? W'(1) : b;
            sb  = $signed(bb);
            su  = int'(a) + int'(bb);
            r   = su[W-1:0];
            c   = su[W];
            ss  = sa + sb;
            v   = (ss > MAXS) || (ss < MINS);
            upd = 1'b1;
         end
         T_SUB, T_CMP, T_DEC: begin
            bb  = (op == T_DEC) ? W'(1) : b;
            sb  = $signed(bb);
            r   = a - bb;
            c   = a < bb;
            ss  = sa - sb;
            v   = (ss > MAXS) || (ss < MINS);
            upd = 1'b1;
         end
         T_AND: begin r = a & b; upd = 1'b1; end
         T_OR:  begin r = a | b; upd = 1'b1; end
         T_XOR: begin r = a ^ b; upd = 1'b1; end
         T_NOT: begin r = ~a;    upd = 1'b1; end
         T_NOP: r = '0;
         T_XCHG: r2 = a;
         T_SAR, T_SLR, T_SAL, T_SLL: begin
            k   = (int'(b) > W) ? W : int'(b);
            lat = 1 + k;
            upd = 1'b1;
            if (op == T_SAR) begin
               ss = sa >>> k;
               r  = ss[W-1:0];
            end else if (op == T_SLR) begin
               r = a >> k;
            end else begin
               r = a << k;
            end
            if (k > 0) c = (op == T_SAR || op == T_SLR) ? a[k-1] : a[W-k];
            v = r[W-1] != a[W-1];
         end
         T_ROL, T_ROR: begin
            k   = int'(b) % W;
            lat = 1 + k;
            upd = 1'b1;
            aa  = {a, a};
            if (op == T_ROL) begin
               aa = aa << k;
               r  = aa[2*W-1:W];
               if (k > 0) c = r[0];
            end else begin
               aa = aa >> k;
               r  = aa[W-1:0];
               if (k > 0) c = r[W-1];
            end
            v = r[W-1] != a[W-1];
         end
         T_MUL: begin
            p   = int'(a) * int'(b);
            r   = p[W-1:0];
            r2  = p[2*W-1:W];
            lat = 1 + W;
         end
         default: r = b;
      endcase
      if (op == T_MUL) mflags = {p[2*W-1], p == 0, r2 != '0, r2 != '0};
      else if (upd) mflags = {r[W-1], r == '0, c, v};
   endtask

   // One transaction from IDLE: accept, wait, check, hold with out_ready low, then drain.
   task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
      logic [W-1:0] er, er2;
      int           elat;
      model(op, a, b, er, er2, elat);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alu_op    = op;
      src_a     = a;
      src_b     = b;
      #1;
      check_eq("in_ready_idle", 16'(in_ready), 16'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_op   = 5'($urandom);
      src_a    = W'($urandom);
      src_b    = W'($urandom);
      obs_lat  = 1;
      while (!out_valid && obs_lat < 40) begin
         check_eq("in_ready_busy", 16'(in_ready), 16'(1'b0));
         @(posedge clk); #1;
         obs_lat++;
      end
      obs_res   = result;
      obs_res2  = result2;
      obs_flags = flags;
      check_eq("latency", 16'(obs_lat), 16'(elat));
      check_eq("out_valid", 16'(out_valid), 16'(1'b1));
      check_eq("result", 16'(result), 16'(er));
      check_eq("result2", 16'(result2), 16'(er2));
      check_eq("flags", 16'(flags), 16'(mflags));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("hold_valid", 16'(out_valid), 16'(1'b1));
         check_eq("hold_ready", 16'(in_ready), 16'(1'b0));
         check_eq("hold_result", 16'({result, result2}), 16'({er, er2}));
         check_eq("hold_flags", 16'(flags), 16'(mflags));
      end
      out_ready = 1'b1;
      #1;
      check_eq("in_ready_done", 16'(in_ready), 16'(1'b1));
      @(posedge clk); #1;
      check_eq("drained", 16'(out_valid), 16'(1'b0));
      out_ready = 1'b0;
   endtask

   initial begin
      logic [4:0]   sc_ops [8];
      logic [4:0]   op;
      logic [W-1:0] a, b, er, er2;
      int           elat;
      sc_ops = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_INC, T_DEC, T_CMP};
      n_checks  = 0;
      n_fail    = 0;
      mflags    = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = '0;
      src_a     = '0;
      src_b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 16'(out_valid), 16'(1'b0));
      check_eq("rst_in_ready", 16'(in_ready), 16'(1'b1));
      check_eq("rst_result", 16'({result, result2}), 16'h0000);
      check_eq("rst_flags", 16'(flags), 16'h0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(T_ADD, 8'h7F, 8'h01, 0);
      check_eq("add_res", 16'(obs_res), 16'h80);
      check_eq("add_flags", 16'(obs_flags), 16'b1001);
      check_eq("add_lat", 16'(obs_lat), 16'd1);
      run_op(T_SUB, 8'h00, 8'h01, 1);
      check_eq("sub_res", 16'(obs_res), 16'hFF);
      check_eq("sub_flags", 16'(obs_flags), 16'b1010);
      run_op(T_MOV, 8'h00, 8'h55, 0);
      check_eq("mov_res", 16'(obs_res), 16'h55);
      check_eq("mov_flags", 16'(obs_flags), 16'b1010);
      run_op(T_SAR, 8'h90, 8'd2, 0);
      check_eq("sar_res", 16'(obs_res), 16'hE4);
      check_eq("sar_c", 16'(obs_flags[1]), 16'(1'b0));
      check_eq("sar_lat", 16'(obs_lat), 16'd3);
      run_op(T_ROL, 8'h81, 8'd1, 0);
      check_eq("rol_res", 16'(obs_res), 16'h03);
      check_eq("rol_c", 16'(obs_flags[1]), 16'(1'b1));
      run_op(T_SLR, 8'h80, 8'd9, 0);
      check_eq("slr_res", 16'(obs_res), 16'h00);
      check_eq("slr_z", 16'(obs_flags[2]), 16'(1'b1));
      check_eq("slr_lat", 16'(obs_lat), 16'd9);
      run_op(T_MUL, 8'h12, 8'h34, 2);
      check_eq("mul_res", 16'({obs_res2, obs_res}), 16'h03A8);
      check_eq("mul_cv", 16'(obs_flags[1:0]), 16'b11);
      check_eq("mul_lat", 16'(obs_lat), 16'd9);

      // XCHG held for five cycles, then a back-to-back stream taken on release
      model(T_XCHG, 8'h3C, 8'hC3, er, er2, elat);
      in_valid = 1'b1;
      alu_op   = T_XCHG;
      src_a    = 8'h3C;
      src_b    = 8'hC3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("xchg_res", 16'({result, result2}), 16'hC33C);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("xchg_hold", 16'({result, result2}), 16'hC33C);
         check_eq("xchg_valid", 16'(out_valid), 16'(1'b1));
         check_eq("xchg_ready", 16'(in_ready), 16'(1'b0));
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         op = (i == 0) ? T_ADD : sc_ops[$urandom_range(0, 7)];
         a  = W'($urandom);
         b  = W'($urandom);
         model(op, a, b, er, er2, elat);
         in_valid = 1'b1;
         alu_op   = op;
         src_a    = a;
         src_b    = b;
         #1;
         check_eq("b2b_ready", 16'(in_ready), 16'(1'b1));
         @(posedge clk); #1;
         check_eq("b2b_valid", 16'(out_valid), 16'(1'b1));
         check_eq("b2b_result", 16'({result, result2}), 16'({er, er2}));
         check_eq("b2b_flags", 16'(flags), 16'(mflags));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("b2b_drain", 16'(out_valid), 16'(1'b0));
      out_ready = 1'b0;

      // Reset in the middle of a multiply
      run_op(T_SUB, 8'h00, 8'h01, 0);
      in_valid = 1'b1;
      alu_op   = T_MUL;
      src_a    = 8'hFF;
      src_b    = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("mid_mul_busy", 16'(in_ready), 16'(1'b0));
      rst_n = 1'b0;
      #1;
      check_eq("abort_valid", 16'(out_valid), 16'(1'b0));
      check_eq("abort_ready", 16'(in_ready), 16'(1'b1));
      check_eq("abort_flags", 16'(flags), 16'h0);
      mflags = '0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(T_ADD, 8'h01, 8'h01, 0);
      check_eq("post_rst_add", 16'(obs_res), 16'h02);

      for (int i = 0; i < 250; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = W'($urandom);
         b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
         run_op(op, a, b, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
